mem_port_arbiter: RTL and testbench

- Shares the single-port memory between the core's instruction-fetch path and its load/store path.
- Serialises requests with a valid/grant handshake, tracks one outstanding access, and routes the response back to its owner.
- Load/store has fixed priority; a starvation counter bounds how long fetch can be locked out.
- Sits between the core datapath and the unified memory macro.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch path and
// the load/store path. One access outstanding at a time, load/store has fixed
// priority, and a starvation counter guarantees fetch a slot after
// STARVE_MAX consecutive load/store grants taken while fetch was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t     state;
  owner_t     owner;
  logic       owner_we;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;

  // rel_q[1] rises on the second edge after reset release, so the first full
  // cycle after release stays quiet even with requests held.
  logic [1:0] rel_q;
  logic       ready;

  logic       resp;
  logic       slot;
  logic       starved;
  logic       ls_win;
  logic       if_win;

  assign ready = rel_q[1];

  // Issue-slot detection and winner selection.
  always_comb begin
    resp    = (state == BUSY) && (lat_cnt == 3'd1);
    slot    = ready && ((state == IDLE) || resp);
    starved = if_req && (starve_cnt == STARVE_LIM);
    ls_win  = slot && ls_req && !starved;
    if_win  = slot && if_req && !ls_win;
  end

  // Grant, memory-side muxing and response routing.
  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_en    = if_win || ls_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (ls_win) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end else if (if_win) begin
      mem_addr  = if_addr;
      mem_be    = '1;
    end
    if_rvalid = resp && (owner == OWN_IF);
    ls_rvalid = resp && (owner == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = (ls_rvalid && !owner_we) ? mem_rdata : '0;
    busy      = (state == BUSY);
  end

  // Transaction FSM, latency countdown and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_q      <= '0;
      state      <= IDLE;
      owner      <= OWN_IF;
      owner_we   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      rel_q <= {rel_q[0], 1'b1};

      if (ls_win || if_win) begin
        state    <= BUSY;
        owner    <= ls_win ? OWN_LS : OWN_IF;
        owner_we <= ls_win && ls_we;
        lat_cnt  <= LAT_INIT;
      end else if (state == BUSY) begin
        if (resp) begin
          state   <= IDLE;
          lat_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end

      if (!if_req || if_win) begin
        starve_cnt <= '0;
      end else if (ls_win && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share
// stimulus; each has its own memory model and response scoreboard.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;

  logic [1:0]       if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [1:0][31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_be;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc_n = 0;

  typedef struct packed {
    logic        ls;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h4) return 32'hFFE0_8093;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic bit all_zero(input int g);
    return (if_gnt[g] === 1'b0) && (if_rvalid[g] === 1'b0) && (if_rdata[g] === 32'h0) &&
           (ls_gnt[g] === 1'b0) && (ls_rvalid[g] === 1'b0) && (ls_rdata[g] === 32'h0) &&
           (mem_en[g] === 1'b0) && (mem_we[g] === 1'b0) && (mem_addr[g] === 32'h0) &&
           (mem_wdata[g] === 32'h0) && (mem_be[g] === 4'h0) && (busy[g] === 1'b0);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_be(ls_be), .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );

    // Memory model: returns data for every access (stores too) LAT cycles later.
    logic [31:0] pa [4];
    logic        pv [4];
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) begin
          pv[k] <= 1'b0;
          pa[k] <= 32'h0;
        end
      end else begin
        pa[0] <= mem_addr[g];
        pv[0] <= mem_en[g];
        for (int k = 1; k < 4; k++) begin
          pa[k] <= pa[k-1];
          pv[k] <= pv[k-1];
        end
      end
    end
    assign mem_rdata[g] = pv[LAT-1] ? mdata(pa[LAT-1]) : 32'h0;

    // Scoreboard: expectation pushed at grant, popped at response.
    exp_t q[$];
    always @(negedge clk) begin
      exp_t e;
      logic [31:0] got;
      if (reset) begin
        q.delete();
      end else begin
        if (if_rvalid[g] || ls_rvalid[g]) begin
          checks++;
          got = ls_rvalid[g] ? ls_rdata[g] : if_rdata[g];
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected dut%0d: rvalid if=%0b ls=%0b at cycle %0d, nothing outstanding",
                     g, if_rvalid[g], ls_rvalid[g], cyc_n);
          end else begin
            e = q.pop_front();
            if ((ls_rvalid[g] !== e.ls) || (if_rvalid[g] === ls_rvalid[g]) ||
                (got !== e.data) || (cyc_n !== e.due)) begin
              failures++;
              $display("FAIL sb_resp dut%0d: got if=%0b ls=%0b data=%h cycle=%0d, need ls=%0b data=%h cycle=%0d",
                       g, if_rvalid[g], ls_rvalid[g], got, cyc_n, e.ls, e.data, e.due);
            end
          end
        end else if ((q.size() != 0) && (q[0].due < cyc_n)) begin
          checks++;
          failures++;
          $display("FAIL sb_missing dut%0d: no rvalid by cycle %0d, need one at cycle %0d",
                   g, cyc_n, q[0].due);
          void'(q.pop_front());
        end
        if (if_gnt[g]) q.push_back('{1'b0, mdata(if_addr), 32'(cyc_n + LAT)});
        if (ls_gnt[g]) q.push_back('{1'b1, ls_we ? 32'h0 : mdata(ls_addr), 32'(cyc_n + LAT)});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, need finish before 500us");
    $fatal(1);
  end

  task automatic drain();
    bit idle = 0;
    @(posedge clk); #1;
    if_req = 0; ls_req = 0; ls_we = 0;
    for (int k = 0; k < 30 && !idle; k++) begin
      @(negedge clk);
      if (busy === 2'b00) idle = 1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL drain: busy=%b after 30 cycles, need 00", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1; if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL reset_idle: outputs not all 0 during reset, need 0");
    end
    if_req = 1; if_addr = 32'h8;
    #1;
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL reset_req: outputs not all 0 during reset with req, need 0");
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL release_cycle: gnt=%b, need all outputs 0", if_gnt);
    end
    @(negedge clk);
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL post_release_cycle: gnt=%b, need all outputs 0", if_gnt);
    end
    @(negedge clk);
    checks++;
    if (if_gnt !== 2'b11) begin
      failures++; $display("FAIL first_grant: if_gnt=%b, need 11", if_gnt);
    end
    drain();
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h4;
    @(negedge clk);
    checks++;
    if ({if_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_be[0], mem_wdata[0]} !==
        {1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0}) begin
      failures++;
      $display("FAIL fetch_issue: gnt=%b en=%b we=%b addr=%h be=%h wdata=%h, need 1 1 0 4 f 0",
               if_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_be[0], mem_wdata[0]);
    end
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    checks++;
    if ({if_rvalid[0], if_rdata[0], busy[0]} !== {1'b1, 32'hFFE0_8093, 1'b1}) begin
      failures++;
      $display("FAIL fetch_resp: rvalid=%b rdata=%h busy=%b, need 1 ffe08093 1",
               if_rvalid[0], if_rdata[0], busy[0]);
    end
    @(negedge clk);
    checks++;
    if ({busy[0], if_rvalid[0], if_rdata[0]} !== {1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL fetch_done: busy=%b rvalid=%b rdata=%h, need 0 0 0",
               busy[0], if_rvalid[0], if_rdata[0]);
    end
    drain();
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h80; ls_req = 1; ls_we = 0; ls_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({ls_gnt[1], if_gnt[1], mem_addr[1]} !== {1'b1, 1'b0, 32'h100}) begin
      failures++;
      $display("FAIL prio_issue: ls_gnt=%b if_gnt=%b addr=%h, need 1 0 00000100",
               ls_gnt[1], if_gnt[1], mem_addr[1]);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) ls_req = 0;
      if (k == 4) if_req = 0;
      @(negedge clk);
      checks++;
      if (k < 3) begin
        if ({if_gnt[1], busy[1]} !== 2'b01) begin
          failures++;
          $display("FAIL prio_wait k=%0d: if_gnt=%b busy=%b, need 0 1", k, if_gnt[1], busy[1]);
        end
      end else if (k == 3) begin
        if ({ls_rvalid[1], ls_rdata[1], if_gnt[1], mem_addr[1]} !==
            {1'b1, mdata(32'h100), 1'b1, 32'h80}) begin
          failures++;
          $display("FAIL prio_handover: ls_rvalid=%b rdata=%h if_gnt=%b addr=%h, need 1 %h 1 00000080",
                   ls_rvalid[1], ls_rdata[1], if_gnt[1], mem_addr[1], mdata(32'h100));
        end
      end else if (k < 6) begin
        if (if_rvalid[1] !== 1'b0) begin
          failures++; $display("FAIL prio_early k=%0d: if_rvalid=%b, need 0", k, if_rvalid[1]);
        end
      end else begin
        if ({if_rvalid[1], if_rdata[1]} !== {1'b1, mdata(32'h80)}) begin
          failures++;
          $display("FAIL prio_fetch_resp: rvalid=%b rdata=%h, need 1 %h",
                   if_rvalid[1], if_rdata[1], mdata(32'h80));
        end
      end
    end
    drain();
  endtask

  task automatic test_starve();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h14; ls_req = 1; ls_we = 0; ls_addr = 32'h10;
    for (int k = 0; k < 12; k++) begin
      bit exp_if;
      exp_if = ((k % 5) == 4);
      @(negedge clk);
      checks++;
      if ({if_gnt[0], ls_gnt[0]} !== {exp_if, !exp_if}) begin
        failures++;
        $display("FAIL starve k=%0d: if_gnt=%b ls_gnt=%b, need %b %b",
                 k, if_gnt[0], ls_gnt[0], exp_if, !exp_if);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
    @(negedge clk);
    checks++;
    if ({ls_gnt[0], mem_en[0], mem_we[0], mem_be[0], mem_wdata[0], mem_addr[0]} !==
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h20}) begin
      failures++;
      $display("FAIL store_issue: gnt=%b en=%b we=%b be=%b wdata=%h addr=%h, need 1 1 1 0011 deadbeef 00000020",
               ls_gnt[0], mem_en[0], mem_we[0], mem_be[0], mem_wdata[0], mem_addr[0]);
    end
    @(posedge clk); #1;
    ls_req = 0; ls_we = 0;
    @(negedge clk);
    checks++;
    if ({ls_rvalid[0], ls_rdata[0]} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL store_resp: rvalid=%b rdata=%h, need 1 00000000", ls_rvalid[0], ls_rdata[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (if_gnt[1] !== 1'b1) begin
      failures++; $display("FAIL mid_issue: if_gnt=%b, need 1", if_gnt[1]);
    end
    @(posedge clk); #1;
    if_req = 0; reset = 1;
    #2;
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL mid_reset_outputs: busy=%b, need all outputs 0", busy);
    end
    #3;
    reset = 0;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (!all_zero(0) || !all_zero(1)) begin
      failures++; $display("FAIL mid_clean_cycle: if_gnt=%b busy=%b, need all outputs 0", if_gnt, busy);
    end
    @(negedge clk);
    checks++;
    if ({if_gnt[1], mem_addr[1]} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL mid_regrant: if_gnt=%b addr=%h, need 1 00000044", if_gnt[1], mem_addr[1]);
    end
    @(posedge clk); #1;
    if_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid[1] !== (k == 3)) begin
        failures++;
        $display("FAIL mid_resp k=%0d: if_rvalid=%b, need %b", k, if_rvalid[1], (k == 3));
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      ls_req = (k < 4); ls_we = 0; ls_addr = 32'(4 * k);
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if ({ls_gnt[0], mem_addr[0]} !== {1'b1, 32'(4 * k)}) begin
          failures++;
          $display("FAIL b2b_issue k=%0d: gnt=%b addr=%h, need 1 %h", k, ls_gnt[0], mem_addr[0], 32'(4 * k));
        end
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if ({ls_rvalid[0], ls_rdata[0], busy[0]} !== {1'b1, mdata(32'(4 * (k - 1))), 1'b1}) begin
          failures++;
          $display("FAIL b2b_resp k=%0d: rvalid=%b rdata=%h busy=%b, need 1 %h 1",
                   k, ls_rvalid[0], ls_rdata[0], busy[0], mdata(32'(4 * (k - 1))));
        end
      end
      if (k == 5) begin
        checks++;
        if ({busy[0], ls_gnt[0]} !== 2'b00) begin
          failures++; $display("FAIL b2b_end: busy=%b gnt=%b, need 0 0", busy[0], ls_gnt[0]);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
